// File: rtl/me_pkg.sv
// Shared constants and types for the motion-estimation PE-array feeder.
package me_pkg;

  localparam int unsigned PIXEL_DEF = 8;

  // One bit selects between the two ping-pong current-block slots.
  typedef logic slot_t;

  localparam logic [1:0] REF_ADJ1_FWD = 2'b00;
  localparam logic [1:0] REF_ADJ8_FWD = 2'b01;
  localparam logic [1:0] REF_ADJ1_REV = 2'b10;
  localparam logic [1:0] REF_ADJ8_REV = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    START,
    SEARCH,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/me_ref_scan.sv
// Reference-window scan: walks the candidate grid in a snake, drives the reference
// shift strobe and source select, and tags each candidate one cycle after its shift.
module me_ref_scan
  import me_pkg::*;
#(
  parameter int unsigned SEARCH_W = 16,
  parameter int unsigned SEARCH_H = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear_i,
  input  logic                        active_i,
  input  logic                        stall_i,
  output logic                        change_ref_o,
  output logic [1:0]                  ref_sel_o,
  output logic                        last_o,
  output logic                        cand_valid_o,
  output logic [$clog2(SEARCH_W)-1:0] cand_x_o,
  output logic [$clog2(SEARCH_H)-1:0] cand_y_o
);

  localparam int unsigned XW = $clog2(SEARCH_W);
  localparam int unsigned YW = $clog2(SEARCH_H);

  logic [XW-1:0] col_q, col_d;
  logic [YW-1:0] row_q, row_d;
  logic [1:0]    sel_q, sel_c;
  logic [XW-1:0] x_c;
  logic          col_last, row_last;
  logic          cand_valid_q;
  logic [XW-1:0] cand_x_q;
  logic [YW-1:0] cand_y_q;

  assign change_ref_o = active_i && !stall_i && !rst;
  assign col_last     = (col_q == XW'(SEARCH_W - 1));
  assign row_last     = (row_q == YW'(SEARCH_H - 1));
  assign last_o       = change_ref_o && col_last && row_last;

  // Row starts step down by a full block; odd rows walk right-to-left.
  always_comb begin
    sel_c = REF_ADJ1_FWD;
    if (col_q == '0 && row_q != '0) begin
      sel_c = REF_ADJ8_FWD;
    end else if (row_q[0]) begin
      sel_c = REF_ADJ1_REV;
    end
  end

  assign x_c       = row_q[0] ? (XW'(SEARCH_W - 1) - col_q) : col_q;
  assign ref_sel_o = change_ref_o ? sel_c : sel_q;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear_i) begin
      col_d = '0;
      row_d = '0;
    end else if (change_ref_o) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      sel_q        <= REF_ADJ1_FWD;
      cand_valid_q <= 1'b0;
      cand_x_q     <= '0;
      cand_y_q     <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      cand_valid_q <= change_ref_o;
      if (change_ref_o) begin
        sel_q    <= sel_c;
        cand_x_q <= x_c;
        cand_y_q <= row_q;
      end
    end
  end

  assign cand_valid_o = cand_valid_q;
  assign cand_x_o     = cand_x_q;
  assign cand_y_o     = cand_y_q;

endmodule

// File: rtl/me_pe_feeder.sv
// Drive side of the ME PE array: loads current blocks into two ping-pong slots and
// sequences the snake search of whichever slot is full, overlapping the two.
module me_pe_feeder
  import me_pkg::*;
#(
  parameter int unsigned PIXEL    = PIXEL_DEF,
  parameter int unsigned PE_NUM   = 64,
  parameter int unsigned SEARCH_W = 16,
  parameter int unsigned SEARCH_H = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [PIXEL-1:0]            s_data,
  input  logic                        stall,
  output logic [PIXEL-1:0]            in_curr,
  output logic                        in_curr_enable,
  output logic [2:0]                  CB_select,
  output logic                        change_curr,
  output logic [2:0]                  abs_Control,
  output logic                        change_ref,
  output logic [1:0]                  ref_input_Control,
  output logic                        cand_valid,
  output logic [$clog2(SEARCH_W)-1:0] cand_x,
  output logic [$clog2(SEARCH_H)-1:0] cand_y,
  output logic                        blk_done
);

  localparam int unsigned BW = $clog2(PE_NUM);

  logic [BW-1:0] beat_q;
  slot_t         wr_slot_q, rd_slot_q, abs_slot_q;
  logic [1:0]    full_q, full_set, full_clr;
  logic          accept, load_last;
  state_e        state_q;
  logic          change_curr_q, blk_done_q;
  logic          scan_last;

  // Loader: pixels pass straight through to PE[0] on every accepted beat.
  assign s_ready        = !rst && !full_q[wr_slot_q];
  assign accept         = s_valid && s_ready;
  assign in_curr_enable = accept;
  assign in_curr        = accept ? s_data : '0;
  assign load_last      = accept && (beat_q == BW'(PE_NUM - 1));
  assign CB_select      = {2'b00, wr_slot_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q    <= '0;
      wr_slot_q <= 1'b0;
    end else if (accept) begin
      if (load_last) begin
        beat_q    <= '0;
        wr_slot_q <= ~wr_slot_q;
      end else begin
        beat_q <= beat_q + 1'b1;
      end
    end
  end

  // Loader only ever fills an empty slot, so set and clear never collide.
  always_comb begin
    full_set = '0;
    full_clr = '0;
    if (load_last) full_set[wr_slot_q] = 1'b1;
    if (state_q == DONE) full_clr[rd_slot_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= '0;
    end else begin
      full_q <= (full_q | full_set) & ~full_clr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      rd_slot_q     <= 1'b0;
      abs_slot_q    <= 1'b0;
      change_curr_q <= 1'b0;
      blk_done_q    <= 1'b0;
    end else begin
      change_curr_q <= 1'b0;
      blk_done_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (full_q[rd_slot_q]) begin
            state_q       <= START;
            change_curr_q <= 1'b1;
            abs_slot_q    <= rd_slot_q;
          end
        end
        START:  state_q <= SEARCH;
        SEARCH: if (scan_last) state_q <= DRAIN;
        DRAIN: begin
          state_q    <= DONE;
          blk_done_q <= 1'b1;
        end
        DONE: begin
          state_q   <= IDLE;
          rd_slot_q <= ~rd_slot_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign change_curr = change_curr_q;
  assign blk_done    = blk_done_q;
  assign abs_Control = {2'b00, abs_slot_q};

  me_ref_scan #(
    .SEARCH_W (SEARCH_W),
    .SEARCH_H (SEARCH_H)
  ) u_scan (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (state_q == START),
    .active_i     (state_q == SEARCH),
    .stall_i      (stall),
    .change_ref_o (change_ref),
    .ref_sel_o    (ref_input_Control),
    .last_o       (scan_last),
    .cand_valid_o (cand_valid),
    .cand_x_o     (cand_x),
    .cand_y_o     (cand_y)
  );

endmodule

// File: tb/tb_me_pe_feeder.sv
// Bench for me_pe_feeder with a 4-PE chain and a 4x4 search range; expectations come
// from the snake-scan arithmetic and slot bookkeeping written directly from the rules.
module tb_me_pe_feeder;

  localparam int unsigned PIXEL  = 8;
  localparam int unsigned PE_NUM = 4;
  localparam int unsigned SW     = 4;
  localparam int unsigned SH     = 4;
  localparam int          N      = SW * SH;

  logic       clk = 1'b0;
  logic       rst, s_valid, s_ready, stall;
  logic [7:0] s_data, in_curr;
  logic       in_curr_enable, change_curr, change_ref, cand_valid, blk_done;
  logic [2:0] CB_select, abs_Control;
  logic [1:0] ref_input_Control, cand_x, cand_y;

  int         total = 0;
  int         bad   = 0;
  logic [1:0] last_sel = 2'b00;

  always #5 clk = ~clk;

  me_pe_feeder #(
    .PIXEL    (PIXEL),
    .PE_NUM   (PE_NUM),
    .SEARCH_W (SW),
    .SEARCH_H (SH)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .s_valid           (s_valid),
    .s_ready           (s_ready),
    .s_data            (s_data),
    .stall             (stall),
    .in_curr           (in_curr),
    .in_curr_enable    (in_curr_enable),
    .CB_select         (CB_select),
    .change_curr       (change_curr),
    .abs_Control       (abs_Control),
    .change_ref        (change_ref),
    .ref_input_Control (ref_input_Control),
    .cand_valid        (cand_valid),
    .cand_x            (cand_x),
    .cand_y            (cand_y),
    .blk_done          (blk_done)
  );

  // Candidate k in snake order: row k/SW, odd rows reversed.
  function automatic int ex(input int k);
    int r = k / SW;
    int c = k % SW;
    return (r % 2 == 1) ? (SW - 1 - c) : c;
  endfunction

  function automatic int ey(input int k);
    return k / SW;
  endfunction

  function automatic logic [1:0] esel(input int k);
    if (k != 0 && k % SW == 0) return 2'b01;
    if ((k / SW) % 2 == 1) return 2'b10;
    return 2'b00;
  endfunction

  task automatic test_reset();
    logic [24:0] outs;
    rst = 1'b1; s_valid = 1'b1; s_data = 8'hAA; stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    outs = {change_curr, change_ref, cand_valid, blk_done, in_curr_enable, CB_select,
            abs_Control, ref_input_Control, cand_x, cand_y, in_curr};
    total++;
    if (s_ready !== 1'b0 || outs !== 25'd0) begin
      bad++;
      $display("FAIL reset_outputs: s_ready=%b outs=%h required s_ready=0 outs=0", s_ready, outs);
    end
    @(posedge clk); #1;
    rst = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    total++;
    if (s_ready !== 1'b1 || change_curr !== 1'b0 || in_curr_enable !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: s_ready=%b change_curr=%b en=%b required 1 0 0",
               s_ready, change_curr, in_curr_enable);
    end
    last_sel = 2'b00;
  endtask

  task automatic test_load_b2b();
    byte unsigned d;
    for (int i = 0; i < PE_NUM; i++) begin
      @(posedge clk); #1;
      d = 8'($urandom); s_valid = 1'b1; s_data = d;
      @(negedge clk);
      total++;
      if (in_curr_enable !== 1'b1 || in_curr !== d || CB_select !== 3'd0 || s_ready !== 1'b1) begin
        bad++;
        $display("FAIL load_beat%0d: en=%b in_curr=%h cb=%0d rdy=%b required 1 %h 0 1",
                 i, in_curr_enable, in_curr, CB_select, s_ready, d);
      end
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(negedge clk);
    total++;
    if (CB_select !== 3'd1 || s_ready !== 1'b1 || change_curr !== 1'b0 || in_curr_enable !== 1'b0) begin
      bad++;
      $display("FAIL load_slot_flip: cb=%0d rdy=%b cc=%b en=%b required 1 1 0 0",
               CB_select, s_ready, change_curr, in_curr_enable);
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (change_curr !== 1'b1 || abs_Control !== 3'd0 || change_ref !== 1'b0) begin
      bad++;
      $display("FAIL start_slot0: cc=%b abs=%0d cr=%b required 1 0 0", change_curr, abs_Control, change_ref);
    end
  endtask

  // Search of slot0 with random stalls while slot1 loads with 1-of-2 gaps.
  task automatic test_search_overlap();
    int k = 0, pk = 0, post = 0, beats = 0, cyc = 0, nblk = 0;
    bit pcr = 1'b0, fin = 1'b0, exp_cr, exp_ready, acc;
    byte unsigned d;
    int row1[4];
    for (int i = 0; i < 4; i++) row1[i] = -1;
    while (!fin && cyc < 200) begin
      cyc++;
      @(posedge clk); #1;
      stall   = (k < N) ? ($urandom_range(3) == 0) : 1'b0;
      s_valid = (beats < PE_NUM) && (cyc % 2 == 0);
      d       = 8'($urandom);
      s_data  = d;
      @(negedge clk);
      if (k == N) post++;
      exp_cr    = (k < N) && !stall;
      exp_ready = (beats < PE_NUM) || (post >= 3);
      acc       = s_valid && exp_ready;
      total++;
      if (change_ref !== exp_cr) begin
        bad++;
        $display("FAIL ov_change_ref k=%0d: got %b required %b", k, change_ref, exp_cr);
      end
      total++;
      if (ref_input_Control !== (exp_cr ? esel(k) : last_sel)) begin
        bad++;
        $display("FAIL ov_ref_sel k=%0d: got %b required %b", k, ref_input_Control,
                 exp_cr ? esel(k) : last_sel);
      end
      total++;
      if (cand_valid !== pcr || (pcr && (cand_x !== 2'(ex(pk)) || cand_y !== 2'(ey(pk))))) begin
        bad++;
        $display("FAIL ov_cand k=%0d: v=%b x=%0d y=%0d required v=%b x=%0d y=%0d",
                 pk, cand_valid, cand_x, cand_y, pcr, ex(pk), ey(pk));
      end
      if (pcr && ey(pk) == 1) row1[pk % SW] = int'(cand_x);
      if (blk_done === 1'b1) nblk++;
      total++;
      if (blk_done !== (post == 2)) begin
        bad++;
        $display("FAIL ov_blk_done post=%0d: got %b required %b", post, blk_done, post == 2);
      end
      total++;
      if (s_ready !== exp_ready) begin
        bad++;
        $display("FAIL ov_s_ready beats=%0d post=%0d: got %b required %b", beats, post, s_ready, exp_ready);
      end
      total++;
      if (in_curr_enable !== acc || (acc && in_curr !== d) ||
          CB_select !== 3'((beats < PE_NUM) ? 1 : 0)) begin
        bad++;
        $display("FAIL ov_loader beats=%0d: en=%b in=%h cb=%0d required en=%b in=%h",
                 beats, in_curr_enable, in_curr, CB_select, acc, d);
      end
      total++;
      if (change_curr !== (post == 4) || abs_Control !== 3'((post >= 4) ? 1 : 0)) begin
        bad++;
        $display("FAIL ov_start post=%0d: cc=%b abs=%0d", post, change_curr, abs_Control);
      end
      if (acc) beats++;
      if (exp_cr) begin
        last_sel = esel(k);
        pk = k;
        k++;
      end
      pcr = exp_cr;
      if (post == 4) fin = 1'b1;
    end
    total++;
    if (!fin) begin
      bad++;
      $display("FAIL ov_timeout: k=%0d post=%0d after %0d cycles", k, post, cyc);
    end
    total++;
    if (row1[0] != 3 || row1[1] != 2 || row1[2] != 1 || row1[3] != 0) begin
      bad++;
      $display("FAIL ov_row1_x: got %0d,%0d,%0d,%0d required 3,2,1,0", row1[0], row1[1], row1[2], row1[3]);
    end
    total++;
    if (nblk != 1) begin
      bad++;
      $display("FAIL ov_blk_count: got %0d required 1", nblk);
    end
  endtask

  // Slot1 search: stall 3 cycles before k=8, then reset where k=9 would issue.
  task automatic test_stall_reset();
    int k = 0, pk = 0, stall_left = 0, cyc = 0;
    bit pcr = 1'b0, stalled = 1'b0, fin = 1'b0, exp_cr;
    logic [24:0] outs;
    s_valid = 1'b0;
    while (!fin && cyc < 100) begin
      cyc++;
      @(posedge clk); #1;
      if (k == 8 && !stalled) begin
        stall_left = 3;
        stalled    = 1'b1;
      end
      stall = (stall_left > 0);
      if (k == 9) begin
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (s_ready !== 1'b0 || change_ref !== 1'b0 || blk_done !== 1'b0) begin
          bad++;
          $display("FAIL sr_in_reset: rdy=%b cr=%b bd=%b required 0 0 0", s_ready, change_ref, blk_done);
        end
        @(posedge clk); #1;
        rst = 1'b0; stall = 1'b0;
        @(negedge clk);
        outs = {change_curr, change_ref, cand_valid, blk_done, in_curr_enable, CB_select,
                abs_Control, ref_input_Control, cand_x, cand_y, in_curr};
        total++;
        if (outs !== 25'd0 || s_ready !== 1'b1) begin
          bad++;
          $display("FAIL sr_after_reset: outs=%h rdy=%b required outs=0 rdy=1", outs, s_ready);
        end
        fin = 1'b1;
      end else begin
        exp_cr = !stall;
        @(negedge clk);
        total++;
        if (change_ref !== exp_cr) begin
          bad++;
          $display("FAIL sr_change_ref k=%0d: got %b required %b", k, change_ref, exp_cr);
        end
        total++;
        if (ref_input_Control !== (exp_cr ? esel(k) : last_sel)) begin
          bad++;
          $display("FAIL sr_ref_sel k=%0d: got %b required %b", k, ref_input_Control,
                   exp_cr ? esel(k) : last_sel);
        end
        total++;
        if (cand_valid !== pcr || (pcr && (cand_x !== 2'(ex(pk)) || cand_y !== 2'(ey(pk))))) begin
          bad++;
          $display("FAIL sr_cand k=%0d: v=%b x=%0d y=%0d required v=%b x=%0d y=%0d",
                   pk, cand_valid, cand_x, cand_y, pcr, ex(pk), ey(pk));
        end
        total++;
        if (abs_Control !== 3'd1 || blk_done !== 1'b0) begin
          bad++;
          $display("FAIL sr_abs: abs=%0d bd=%b required 1 0", abs_Control, blk_done);
        end
        if (stall_left > 0) stall_left--;
        if (exp_cr) begin
          last_sel = esel(k);
          pk = k;
          k++;
        end
        pcr = exp_cr;
      end
    end
    total++;
    if (!fin) begin
      bad++;
      $display("FAIL sr_timeout: k=%0d after %0d cycles", k, cyc);
    end
    last_sel = 2'b00;
    // Both slots are empty after reset: nothing may start or complete.
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if (change_curr !== 1'b0 || blk_done !== 1'b0 || change_ref !== 1'b0) begin
        bad++;
        $display("FAIL sr_idle cyc=%0d: cc=%b bd=%b cr=%b required 0 0 0", i, change_curr, blk_done, change_ref);
      end
    end
  endtask

  // Two blocks loaded back-to-back, then both searched without stalls.
  task automatic test_back_to_back();
    int nref = 0, nc = 0, nblk = 0, nst = 0;
    byte unsigned d;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(posedge clk); #1;
      d = 8'($urandom); s_valid = (cyc < 2 * PE_NUM); s_data = d; stall = 1'b0;
      @(negedge clk);
      if (cyc < 2 * PE_NUM) begin
        total++;
        if (in_curr_enable !== 1'b1 || in_curr !== d || CB_select !== 3'(cyc / PE_NUM)) begin
          bad++;
          $display("FAIL b2b_load%0d: en=%b in=%h cb=%0d required 1 %h %0d",
                   cyc, in_curr_enable, in_curr, CB_select, d, cyc / PE_NUM);
        end
      end
      if (change_ref === 1'b1) begin
        total++;
        if (ref_input_Control !== esel(nref % N)) begin
          bad++;
          $display("FAIL b2b_ref_sel n=%0d: got %b required %b", nref, ref_input_Control, esel(nref % N));
        end
        nref++;
      end
      if (cand_valid === 1'b1) begin
        total++;
        if (cand_x !== 2'(ex(nc % N)) || cand_y !== 2'(ey(nc % N))) begin
          bad++;
          $display("FAIL b2b_cand n=%0d: x=%0d y=%0d required x=%0d y=%0d",
                   nc, cand_x, cand_y, ex(nc % N), ey(nc % N));
        end
        nc++;
      end
      if (change_curr === 1'b1) begin
        total++;
        if (abs_Control !== 3'(nst)) begin
          bad++;
          $display("FAIL b2b_start%0d: abs=%0d required %0d", nst, abs_Control, nst);
        end
        nst++;
      end
      if (blk_done === 1'b1) begin
        nblk++;
        total++;
        if (nc != nblk * N) begin
          bad++;
          $display("FAIL b2b_blk%0d: candidates=%0d required %0d", nblk, nc, nblk * N);
        end
      end
    end
    total++;
    if (nref != 2 * N || nc != 2 * N || nblk != 2 || nst != 2) begin
      bad++;
      $display("FAIL b2b_counts: ref=%0d cand=%0d blk=%0d start=%0d required %0d %0d 2 2",
               nref, nc, nblk, nst, 2 * N, 2 * N);
    end
    total++;
    if (s_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_final_ready: got %b required 1", s_ready);
    end
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; stall = 1'b0;
    test_reset();
    test_load_b2b();
    test_search_overlap();
    test_stall_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
